screen_ctrl: RTL
================

Name: screen_ctrl

Overview:
- Frame-synchronous game-screen sequencer for the background/text overlay chain (end-screen background, then two character-overlay stages).
- Selects the background layer and enables and configures the two character overlay stages.
- Requests from the user and the game core are latched and applied only at a frame boundary, so no frame is ever drawn half-switched.
- Sits beside the VGA pixel pipeline and drives only its static configuration inputs.

Parameters:
- END_FRAMES, 300, minimum number of frames the END screen is shown (5 s at 60 Hz); range 1..65535.
- BLINK_PERIOD, 32, frames per half-period of the "press start" blink; range 1..255.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- vsync_in  in  1  vsync from the VGA timing generator, active-high.
- start_btn  in  1  raw start button, asynchronous.
- game_over  in  1  level from the game core.
- winner  in  2  winner code; valid while game_over=1.
- layer_sel  out  2  background select: 0=MENU, 1=GAME, 2=END; 3 is never driven.
- char_en  out  1  enable for the first character overlay stage.
- char2_en  out  1  enable for the second character overlay stage.
- text_page  out  2  text page for the char stages: 0=title, 1..3 = latched winner+1.
- blink  out  1  blink phase.
- frame_tick  out  1  one-cycle pulse per frame.

Behaviour:
- Frame tick:
  - vsync_in is registered into vs_q.
  - frame_tick is a registered pulse, high for exactly 1 cycle, in the cycle after a cycle where vsync_in=1 and vs_q=0.
- Start button:
  - start_btn goes through a 2-FF synchronizer plus rising-edge detect.
  - A detected edge sets pend_start.
- State machine, 3 states: MENU, PLAY, END.
  - Transitions are evaluated only in a frame_tick cycle and take effect on that clock edge.
  - Outputs are registered, so they change 1 cycle after frame_tick; total latency is vsync rise + 3 cycles.
- MENU -> PLAY: when pend_start=1; pend_start is cleared.
- PLAY -> END: when game_over=1.
  - winner is latched into win_q at that edge.
  - pend_start is cleared.
- END -> MENU:
  - Requires end_cnt == END_FRAMES.
  - Also requires pend_start=1 (see Optional Feature).
  - pend_start is cleared.
- Simultaneous events:
  - In PLAY, game_over has priority; a pending start is discarded.
  - A start edge arriving in the frame_tick cycle itself is kept pending for the next tick.
- pend_start clearing:
  - Cleared on entry to PLAY.
  - Start edges seen while in PLAY are ignored and not latched.
- end_cnt (16 b):
  - Cleared on entry to END.
  - Increments per frame_tick while in END; saturates at END_FRAMES, never wraps.
- blink_cnt (8 b):
  - Counts frame_ticks in MENU and wraps at BLINK_PERIOD-1 -> 0.
  - blink toggles on each wrap.
  - On entry to MENU, blink_cnt and blink are cleared.
- Outputs per state:
  - MENU: layer_sel=0, char_en=1, char2_en=blink, text_page=0.
  - PLAY: layer_sel=1, char_en=0, char2_en=0, text_page=0.
  - END: layer_sel=2, char_en=1, char2_en=1, text_page=win_q+1, saturating at 3.
  - blink=0 outside MENU.
- Reset:
  - state=MENU; layer_sel=0, char_en=1, char2_en=0, text_page=0, blink=0, frame_tick=0.
  - All counters, pend_start, win_q, vs_q and synchronizer flops = 0.
  - Reset mid-frame or mid-END aborts immediately.
  - The first frame_tick after reset requires a fresh vsync rising edge; vsync_in=1 held through reset release gives no tick.

Optional Feature:
- Macro SCREEN_CTRL_AUTO_RESTART_EN.
- Defined: END -> MENU occurs automatically at the first frame_tick with end_cnt == END_FRAMES; pend_start is ignored and cleared in END.
- Undefined: END -> MENU additionally requires pend_start=1; a start pressed before the hold expires stays pending and takes effect once end_cnt == END_FRAMES.

Decomposition:
- vga_pkg holds:
  - screen_t enum: MENU, PLAY, END.
  - Layer codes LAYER_MENU=2'd0, LAYER_GAME=2'd1, LAYER_END=2'd2.
  - TEXT_TITLE=2'd0.
- One sub-module: sync_edge_det (2-FF synchronizer + rising-edge pulse, rst active-low synchronous), used for start_btn.

Test Plan (bench with END_FRAMES=4, BLINK_PERIOD=2):
- Reset release, vsync toggling:
  - layer_sel=0, char_en=1, text_page=0.
  - blink goes 0,0,1,1,0 over the first 5 ticks; char2_en tracks blink.
- Start pulse mid-frame -> no change until next vsync rise; layer_sel=1, char_en=0, char2_en=0 exactly 3 cycles after that rise.
- In PLAY, game_over=1 with winner=2'd1, plus a start edge in the same frame -> END, layer_sel=2, text_page=2, char2_en=1; start discarded.
- Without macro:
  - Start at END frame 1 -> stays END until end_cnt=4, then MENU on that tick.
  - No start -> stays END indefinitely and end_cnt holds at 4.
- With macro: no start -> MENU on the 4th tick after entering END; blink restarts at 0.
- rst=0 for 1 cycle while in END with end_cnt=2 -> next cycle all outputs at reset values; vsync_in held high across release -> no frame_tick until next rise.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared screen-state encoding and layer/text codes for the VGA overlay chain.
package vga_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    PLAY = 2'd1,
    END  = 2'd2
  } screen_t;

  localparam logic [1:0] LAYER_MENU = 2'd0;
  localparam logic [1:0] LAYER_GAME = 2'd1;
  localparam logic [1:0] LAYER_END  = 2'd2;
  localparam logic [1:0] TEXT_TITLE = 2'd0;

  // Winner code to text page: winner+1, pinned at the last page.
  function automatic logic [1:0] win_page(input logic [1:0] w);
    return (w == 2'd3) ? 2'd3 : w + 2'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/screen_ctrl.sv
// Frame-synchronous MENU/PLAY/END sequencer driving background and char-overlay config.
// Build option: SCREEN_CTRL_AUTO_RESTART_EN leaves END automatically once the hold expires.
//
// state | meaning
// MENU  | title screen, "press start" blink on overlay 2
// PLAY  | game background, overlays off
// END   | end background, winner text, held at least END_FRAMES frames
module screen_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned END_FRAMES   = 300,
  parameter int unsigned BLINK_PERIOD = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic [1:0] winner,
  output logic [1:0] layer_sel,
  output logic       char_en,
  output logic       char2_en,
  output logic [1:0] text_page,
  output logic       blink,
  output logic       frame_tick
);

  localparam logic [15:0] END_MAX    = 16'(END_FRAMES);
  localparam logic [7:0]  BLINK_WRAP = 8'(BLINK_PERIOD - 1);

  screen_t     state, state_nxt;
  logic        vs_q, vs_armed;
  logic        start_edge;
  logic        pend_start, pend_nxt;
  logic [1:0]  win_q, win_nxt;
  logic [15:0] end_cnt, end_nxt, end_inc;
  logic [7:0]  blink_cnt, bcnt_nxt;
  logic        blink_ph, bph_nxt;

  sync_edge_det u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (start_btn),
    .pulse (start_edge)
  );

  // vs_armed blocks a tick from a vsync level that was already high at reset release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_q       <= 1'b0;
      vs_armed   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vsync_in;
      vs_armed   <= vs_armed | ~vsync_in;
      frame_tick <= vsync_in & ~vs_q & vs_armed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= MENU;
      pend_start <= 1'b0;
      win_q      <= 2'd0;
      end_cnt    <= 16'd0;
      blink_cnt  <= 8'd0;
      blink_ph   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_start <= pend_nxt;
      win_q      <= win_nxt;
      end_cnt    <= end_nxt;
      blink_cnt  <= bcnt_nxt;
      blink_ph   <= bph_nxt;
    end
  end

  // The END hold is judged on the post-increment count, so END lasts END_FRAMES ticks.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_start | start_edge;
    win_nxt   = win_q;
    end_nxt   = end_cnt;
    bcnt_nxt  = blink_cnt;
    bph_nxt   = blink_ph;
    end_inc   = (end_cnt == END_MAX) ? end_cnt : end_cnt + 16'd1;

    case (state)
      MENU: begin
        if (frame_tick) begin
          if (pend_start) begin
            state_nxt = PLAY;
            pend_nxt  = 1'b0;
          end else if (blink_cnt >= BLINK_WRAP) begin
            bcnt_nxt = 8'd0;
            bph_nxt  = ~blink_ph;
          end else begin
            bcnt_nxt = blink_cnt + 8'd1;
          end
        end
      end
      PLAY: begin
        pend_nxt = 1'b0;
        if (frame_tick && game_over) begin
          state_nxt = END;
          win_nxt   = winner;
          end_nxt   = 16'd0;
        end
      end
      END: begin
`ifdef SCREEN_CTRL_AUTO_RESTART_EN
        pend_nxt = 1'b0;
        if (frame_tick) begin
          end_nxt = end_inc;
          if (end_inc == END_MAX) begin
            state_nxt = MENU;
            bcnt_nxt  = 8'd0;
            bph_nxt   = 1'b0;
          end
        end
`else
        if (frame_tick) begin
          end_nxt = end_inc;
          if (end_inc == END_MAX && pend_start) begin
            state_nxt = MENU;
            pend_nxt  = 1'b0;
            bcnt_nxt  = 8'd0;
            bph_nxt   = 1'b0;
          end
        end
`endif
      end
      default: begin
        state_nxt = MENU;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      layer_sel <= LAYER_MENU;
      char_en   <= 1'b1;
      char2_en  <= 1'b0;
      text_page <= TEXT_TITLE;
      blink     <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          layer_sel <= LAYER_GAME;
          char_en   <= 1'b0;
          char2_en  <= 1'b0;
          text_page <= TEXT_TITLE;
          blink     <= 1'b0;
        end
        END: begin
          layer_sel <= LAYER_END;
          char_en   <= 1'b1;
          char2_en  <= 1'b1;
          text_page <= win_page(win_q);
          blink     <= 1'b0;
        end
        default: begin
          layer_sel <= LAYER_MENU;
          char_en   <= 1'b1;
          char2_en  <= blink_ph;
          text_page <= TEXT_TITLE;
          blink     <= blink_ph;
        end
      endcase
    end
  end

endmodule
